// File: rtl/hdc_pkg.sv
// Shared hypervector-encoder types: bundler state encoding and chunk-count helper.
package hdc_pkg;

  typedef enum logic [1:0] {
    BND_IDLE = 2'd0,
    BND_RUN  = 2'd1,
    BND_DONE = 2'd2
  } bundler_state_t;

  function automatic int num_chunks(input int dimensions, input int par_bits);
    return dimensions / par_bits;
  endfunction

endpackage

// File: rtl/dim_chunk_counter.sv
// Dimension chunk offset register: steps by PAR_BITS, flags the final chunk.
// Latency: d updates one cycle after clr/adv; last is combinational on d.
// Backpressure: adv low holds d; adv on the last chunk returns d to 0.
module dim_chunk_counter
  import hdc_pkg::*;
#(
  parameter int DIMENSIONS = 10000,
  parameter int PAR_BITS   = 10,
  parameter int DW         = $clog2(DIMENSIONS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [DW-1:0] d,
  output logic          last
);

  localparam logic [DW-1:0] LAST_D = DW'(DIMENSIONS - PAR_BITS);
  localparam logic [DW:0]   STEP   = (DW+1)'(PAR_BITS);

  logic [DW-1:0] d_q;
  logic [DW:0]   d_inc;

  assign d_inc = {1'b0, d_q} + STEP;
  assign last  = (d_q == LAST_D);
  assign d     = d_q;

  // Advancing from the last chunk (or on any carry out) clears instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= '0;
    end else if (clr || (adv && (last || d_inc[DW]))) begin
      d_q <= '0;
    end else if (adv) begin
      d_q <= d_inc[DW-1:0];
    end
  end

endmodule

// File: rtl/bundler_ctrl.sv
// Bundler sequencer: walks d over the hypervector in PAR_BITS chunks, pulses done.
// Latency: start -> done in NUM_CHUNKS+1 cycles; outputs decode registered state only.
// Backpressure: with BUNDLER_CTRL_BACKPRESSURE_EN, RUN holds d while out_ready is low.
module bundler_ctrl
  import hdc_pkg::*;
#(
  parameter int DIMENSIONS = 10000,
  parameter int PAR_BITS   = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
`ifdef BUNDLER_CTRL_BACKPRESSURE_EN
  input  logic                          out_ready,
`endif
  output logic [1:0]                    state,
  output logic [$clog2(DIMENSIONS)-1:0] d,
  output logic                          chunk_valid,
  output logic                          chunk_last,
  output logic                          busy,
  output logic                          done
);

  localparam int DW         = $clog2(DIMENSIONS);
  localparam int NUM_CHUNKS = num_chunks(DIMENSIONS, PAR_BITS);

  generate
    if ((DIMENSIONS % PAR_BITS != 0) || (NUM_CHUNKS < 1)) begin : g_bad_params
      $error("bundler_ctrl: DIMENSIONS must be a non-zero multiple of PAR_BITS");
    end
  endgenerate

  bundler_state_t state_q, state_d;
  logic           adv;
  logic           ctr_clr;
  logic           ctr_adv;
  logic           ctr_last;

`ifdef BUNDLER_CTRL_BACKPRESSURE_EN
  assign adv = out_ready;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ctr_clr = 1'b0;
    ctr_adv = 1'b0;
    case (state_q)
      BND_IDLE: begin
        ctr_clr = 1'b1;
        if (start && !abort) state_d = BND_RUN;
      end
      BND_RUN: begin
        if (abort) begin
          state_d = BND_IDLE;
          ctr_clr = 1'b1;
        end else if (adv) begin
          ctr_adv = 1'b1;
          if (ctr_last) state_d = BND_DONE;
        end
      end
      BND_DONE: begin
        state_d = BND_IDLE;
        ctr_clr = 1'b1;
      end
      default: begin
        state_d = BND_IDLE;
        ctr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BND_IDLE;
    else     state_q <= state_d;
  end

  dim_chunk_counter #(
    .DIMENSIONS (DIMENSIONS),
    .PAR_BITS   (PAR_BITS),
    .DW         (DW)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (ctr_clr),
    .adv  (ctr_adv),
    .d    (d),
    .last (ctr_last)
  );

  assign state       = state_q;
  assign chunk_valid = (state_q == BND_RUN);
  assign chunk_last  = (state_q == BND_RUN) && ctr_last;
  assign busy        = (state_q == BND_RUN) || (state_q == BND_DONE);
  assign done        = (state_q == BND_DONE);

endmodule
